// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
package dff_pipe_pkg;

  localparam int unsigned MaxWidth = 64;

  // Default reset/flush value for data stages; callers slice to their width.
  localparam logic [MaxWidth-1:0] DefaultRstVal = '0;

  // Bits needed to hold a count in 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit, with load enable and
// synchronous clear to RST_VAL.
module dff_pipe_stage #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Next state: clear wins over load, otherwise hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) begin
      data_d  = RST_VAL;
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = valid_i;
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i) begin
    data_q  <= data_d;
    valid_q <= valid_d;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// Parameterised shift pipeline of DEPTH data+valid stages with global enable,
// synchronous flush, and a registered count of valid stages.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = DefaultRstVal[WIDTH-1:0],
  localparam int unsigned     CW      = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] data  [DEPTH];
  logic             valid [DEPTH];
  logic             clear;
  logic [CW-1:0]    count_d, count_q;

  // Reset and flush have identical effect on the stages.
  assign clear = rst | flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_data;
    logic             stage_valid;

    if (i == 0) begin : g_head
      assign stage_data  = d;
      assign stage_valid = in_valid;
    end else begin : g_body
      assign stage_data  = data[i-1];
      assign stage_valid = valid[i-1];
    end

    dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i   (clk),
      .clr_i   (clear),
      .load_i  (en),
      .data_i  (stage_data),
      .valid_i (stage_valid),
      .data_o  (data[i]),
      .valid_o (valid[i])
    );
  end

  // Incremental count: one word may enter and one may leave per advance, so the
  // result always equals the popcount and stays within 0..DEPTH.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + CW'(in_valid) - CW'(valid[DEPTH-1]);
    end
  end

  // Count register, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q         = data[DEPTH-1];
  assign out_valid = valid[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RST_VAL=0).
module tb_dff_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [WIDTH-1:0] RV = 8'h00;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic [2:0]       count;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: front = stage 0, back = stage DEPTH-1 (the output).
  ent_t sb[$];

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .d         (d),
    .in_valid  (in_valid),
    .q         (q),
    .out_valid (out_valid),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_clear();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) sb.push_back('{v: 1'b0, d: RV});
  endtask

  function automatic int sb_pop();
    int n = 0;
    foreach (sb[i]) if (sb[i].v) n++;
    return n;
  endfunction

  // Drive one cycle of inputs, update the scoreboard at the edge, then compare.
  task automatic step(input string tag, input logic r, input logic f, input logic e,
                      input logic iv, input logic [WIDTH-1:0] dv);
    ent_t exp_out;
    rst = r; flush = f; en = e; in_valid = iv; d = dv;
    @(posedge clk);
    if (r || f) begin
      sb_clear();
    end else if (e) begin
      sb.push_front('{v: iv, d: dv});
      void'(sb.pop_back());
    end
    #1;
    exp_out = sb[DEPTH-1];
    check({tag, "_q"}, 64'(q), 64'(exp_out.d));
    check({tag, "_ov"}, 64'(out_valid), 64'(exp_out.v));
    check({tag, "_cnt"}, 64'(count), 64'(sb_pop()));
  endtask

  initial begin
    logic [WIDTH-1:0] feed [4];
    logic [2:0]       drain_cnt [4];
    feed[0] = 8'hA1; feed[1] = 8'hB2; feed[2] = 8'hC3; feed[3] = 8'hD4;
    drain_cnt[0] = 3'd3; drain_cnt[1] = 3'd2; drain_cnt[2] = 3'd1; drain_cnt[3] = 3'd0;

    // Reset for two edges, then idle with no valid input.
    step("rst0", 1, 0, 0, 0, 8'h00);
    step("rst1", 1, 0, 1, 1, 8'h99);
    check("rst_q", 64'(q), 64'(8'h00));
    check("rst_cnt", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) step("idle", 0, 0, 1, 0, 8'h00);
    check("idle_ov", 64'(out_valid), 64'd0);

    // Fill with A1..D4.
    for (int i = 0; i < 4; i++) step("fill", 0, 0, 1, 1, feed[i]);
    check("fill_q", 64'(q), 64'(8'hA1));
    check("fill_ov", 64'(out_valid), 64'd1);
    check("fill_cnt", 64'(count), 64'd4);

    // Hold with en=0 while garbage is presented.
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 1, 8'hFF);
    check("hold_q", 64'(q), 64'(8'hA1));
    check("hold_cnt", 64'(count), 64'd4);

    // Steady stream: count stays full while B2..D4 emerge.
    for (int i = 1; i < 4; i++) begin
      step("strm", 0, 0, 1, 1, 8'hE4 + 8'(i));
      check("strm_q", 64'(q), 64'(feed[i]));
      check("strm_cnt", 64'(count), 64'd4);
    end

    // Drain with in_valid=0: count steps down to 0.
    for (int i = 0; i < 4; i++) begin
      step("drn", 0, 0, 1, 0, 8'h0F);
      check("drn_cnt", 64'(count), 64'(drain_cnt[i]));
    end

    // Refill, then flush with a valid word presented: it must never emerge.
    for (int i = 0; i < 4; i++) step("rfl", 0, 0, 1, 1, 8'h11 * 8'(i + 1));
    check("rfl_cnt", 64'(count), 64'd4);
    step("flsh", 0, 1, 1, 1, 8'h55);
    check("flsh_q", 64'(q), 64'(8'h00));
    check("flsh_ov", 64'(out_valid), 64'd0);
    check("flsh_cnt", 64'(count), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step("pflsh", 0, 0, 1, 0, 8'h00);
      check("pflsh_q", 64'(q), 64'(8'h00));
    end

    // Flush acts even with en=0.
    step("fe0a", 0, 0, 1, 1, 8'h21);
    step("fe0b", 0, 0, 1, 1, 8'h22);
    step("fe0", 0, 1, 0, 1, 8'h23);
    check("fe0_cnt", 64'(count), 64'd0);

    // Two words in flight, reset for one edge, then a fresh word.
    step("rf0", 0, 0, 1, 1, 8'h66);
    step("rf1", 0, 0, 1, 1, 8'h77);
    step("rmid", 1, 0, 1, 1, 8'h78);
    check("rmid_q", 64'(q), 64'(8'h00));
    check("rmid_cnt", 64'(count), 64'd0);
    step("rnew", 0, 0, 1, 1, 8'h88);
    check("rnew_cnt", 64'(count), 64'd1);
    for (int i = 0; i < DEPTH - 1; i++) step("rpost", 0, 0, 1, 0, 8'h00);
    check("rpost_q", 64'(q), 64'(8'h88));
    check("rpost_ov", 64'(out_valid), 64'd1);

    // Reset dominates flush and en.
    step("rall", 1, 1, 1, 1, 8'h5A);
    check("rall_ov", 64'(out_valid), 64'd0);

    // Random mixed traffic checked against the scoreboard.
    for (int i = 0; i < 60; i++) begin
      step("rnd", 0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
